demux_1_4_stream: RTL and testbench

- Registered 1-to-4 stream demultiplexer. It is the distribution-side counterpart of the 4:1 mux tree.
- One upstream valid/ready stream carries data, a 2-bit destination select and a packet "last" marker. Each beat is steered to one of four downstream valid/ready channels, each buffered by a one-entry output register.
- Routing locks per packet: the destination is taken from the first beat of a packet and held until the beat with last=1 is accepted.

---
 rtl/demux_1_4_stream.sv | 145 ++++++++++++++
 tb/tb_demux_1_4_stream.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream
// Registered 1-to-4 valid/ready stream demultiplexer. Each upstream beat is
// steered to one of four downstream channels, each of which is buffered by a
// one-entry output register. The destination is taken from the first beat of
// a packet and held until the beat carrying d_last is accepted.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   d, sel, d_last  upstream data, destination index, end-of-packet marker
//   d_valid/d_ready upstream handshake (d_ready forced low during reset)
//   y0..y3          downstream data, one per channel
//   y_last, y_valid per-channel last flag and valid (bit i = channel i)
//   y_ready         per-channel downstream ready (bit i = channel i)
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             d_last,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_last,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  route_q, route_d;
  logic [3:0][WIDTH-1:0]       data_q, data_d;
  logic [3:0]                  last_q, last_d;
  logic [3:0]                  valid_q, valid_d;

  logic [1:0]                  target_s;
  logic                        ready_s;
  logic                        accept_s;

  // Destination select: live sel on a packet's first beat, locked route after.
  always_comb begin
    target_s = 2'b00;
    case (state_q)
      IDLE:    target_s = sel;
      LOCKED:  target_s = route_q;
      default: target_s = 2'b00;
    endcase
  end

  // Upstream ready looks only at the target slot so other channels' stalls
  // never block this stream; a slot draining this cycle can take a new beat.
  always_comb begin
    if (rst) begin
      ready_s = 1'b0;
    end else begin
      ready_s = !valid_q[target_s] || y_ready[target_s];
    end
    accept_s = d_valid && ready_s;
  end

  // Packet-lock FSM: the route is captured only when a multi-beat packet starts.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    if (accept_s) begin
      case (state_q)
        IDLE: begin
          if (!d_last) begin
            state_d = LOCKED;
            route_d = sel;
          end else begin
            state_d = IDLE;
          end
        end
        LOCKED: begin
          if (d_last) begin
            state_d = IDLE;
          end else begin
            state_d = LOCKED;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output slots: drain clears valid, a load in the same cycle overrides the
  // drain so back-to-back beats flow without a bubble.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    for (int i = 0; i < 4; i++) begin
      if (valid_q[i] && y_ready[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
      if (accept_s && (target_s == 2'(i))) begin
        data_d[i]  = d;
        last_d[i]  = d_last;
        valid_d[i] = 1'b1;
      end else begin
        data_d[i]  = data_q[i];
        last_d[i]  = last_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 2'b00;
      data_q  <= '0;
      last_q  <= 4'b0000;
      valid_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign d_ready = ready_s;
  assign y0      = data_q[0];
  assign y1      = data_q[1];
  assign y2      = data_q[2];
  assign y3      = data_q[3];
  assign y_last  = last_q;
  assign y_valid = valid_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Testbench for demux_1_4_stream: directed steps from the test plan followed
// by a randomized phase, all checked against a packet-level scoreboard that
// keeps one queue of expected beats per downstream channel.
module tb_demux_1_4_stream;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             d_last;
  logic             d_valid;
  logic             d_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       y_last;
  logic [3:0]       y_valid;
  logic [3:0]       y_ready;

  demux_1_4_stream #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .sel     (sel),
    .d_last  (d_last),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y0      (y0),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .y_last  (y_last),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared;
  int mismatched;

  // Reference model: expected beats {last,data} per channel, plus packet lock.
  logic [WIDTH:0] exp_q [4][$];
  logic           in_pkt;
  logic [1:0]     pkt_route;
  logic           obs_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] get_y(input int i);
    case (i)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      default: return y3;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] dd,
                       input logic l, input logic [3:0] rdy);
    d_valid = v;
    sel     = s;
    d       = dd;
    d_last  = l;
    y_ready = rdy;
  endtask

  // One clock cycle: check at negedge, then advance the model at posedge.
  task automatic cycle();
    logic [1:0] tgt;
    logic       exp_ready;
    logic       do_push;
    logic [3:0] do_pop;
    @(negedge clk);
    tgt       = in_pkt ? pkt_route : sel;
    exp_ready = !rst && (exp_q[tgt].size() == 0 || y_ready[tgt]);
    obs_ready = d_ready;
    check("d_ready", {31'd0, d_ready}, {31'd0, exp_ready});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("y_valid[%0d]", i), {31'd0, y_valid[i]},
            {31'd0, (exp_q[i].size() != 0)});
      if (exp_q[i].size() != 0) begin
        check($sformatf("y%0d", i), {28'd0, get_y(i)}, {28'd0, exp_q[i][0][WIDTH-1:0]});
        check($sformatf("y_last[%0d]", i), {31'd0, y_last[i]}, {31'd0, exp_q[i][0][WIDTH]});
      end
    end
    do_push = d_valid && exp_ready;
    for (int i = 0; i < 4; i++) do_pop[i] = (exp_q[i].size() != 0) && y_ready[i];
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
      in_pkt = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) if (do_pop[i]) void'(exp_q[i].pop_front());
      if (do_push) begin
        exp_q[tgt].push_back({d_last, d});
        if (!in_pkt && !d_last) begin
          in_pkt    = 1'b1;
          pkt_route = sel;
        end else if (d_last) begin
          in_pkt = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [3:0] rnd_rdy;
    compared   = 0;
    mismatched = 0;
    in_pkt     = 1'b0;
    pkt_route  = 2'b00;
    rst        = 1'b1;
    drive(1'b1, 2'd0, 4'h1, 1'b1, 4'b1111);

    // Reset for two cycles with d_valid held high.
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111);
    check("rst y_valid", {28'd0, y_valid}, 32'd0);
    check("rst y_last", {28'd0, y_last}, 32'd0);
    check("rst y0..y3", {16'd0, y3, y2, y1, y0}, 32'd0);
    cycle();

    // Single-beat routing to each channel on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 4'(4'hA + i), 1'b1, 4'b1111);
      cycle();
    end
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111);
    cycle();

    // Packet lock: sel changes mid-packet must be ignored.
    drive(1'b1, 2'd2, 4'h7, 1'b0, 4'b1111); cycle();
    drive(1'b1, 2'd0, 4'hA, 1'b0, 4'b1111); cycle();
    drive(1'b1, 2'd1, 4'h3, 1'b1, 4'b1111); cycle();
    drive(1'b1, 2'd1, 4'h5, 1'b1, 4'b1111); cycle();
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111); cycle();
    check("lock y1", {28'd0, y1}, 32'h5);

    // Back-pressure isolation on channel 0.
    drive(1'b1, 2'd0, 4'h9, 1'b1, 4'b1110); cycle();
    drive(1'b1, 2'd0, 4'h2, 1'b1, 4'b1110); cycle();
    check("stall d_ready", {31'd0, obs_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 2'd3, 4'(4'h3 + k), 1'b1, 4'b1110); cycle();
      check("ch3 pass d_ready", {31'd0, obs_ready}, 32'd1);
    end
    check("held y0", {28'd0, y0}, 32'h9);
    drive(1'b1, 2'd0, 4'h2, 1'b1, 4'b1111); cycle();
    check("release d_ready", {31'd0, obs_ready}, 32'd1);
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111); cycle();

    // Full-throughput stream of 8 beats to channel 1.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 2'd1, 4'(k), (k == 8), 4'b1111); cycle();
      check("stream d_ready", {31'd0, obs_ready}, 32'd1);
    end
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111); cycle();

    // Reset in the middle of a packet to channel 3.
    drive(1'b1, 2'd3, 4'h6, 1'b0, 4'b1111); cycle();
    rst = 1'b1;
    drive(1'b0, 2'd3, 4'h0, 1'b0, 4'b1111); cycle();
    rst = 1'b0;
    check("mid-pkt rst y_valid", {28'd0, y_valid}, 32'd0);
    drive(1'b1, 2'd0, 4'h4, 1'b1, 4'b1111); cycle();
    drive(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111);
    check("after rst y_valid", {28'd0, y_valid}, 32'b0001);
    check("after rst y0", {28'd0, y0}, 32'h4);
    cycle();

    // Randomized traffic with back-pressure and occasional resets.
    for (int n = 0; n < 400; n++) begin
      rnd_rdy = 4'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
            ($urandom_range(0, 2) == 0), rnd_rdy | 4'($urandom));
      cycle();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
